// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO filled by TXDATA stores,
// STATUS readable over the load port, memWait stalls stores into a full FIFO.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        sel,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic        RE,
  input  logic [3:0]  byteena,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        memWait,
  output logic        TX
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e              state_q;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [2:0]          bitcnt_q;
  logic [7:0]          shift_q;
  logic                tx_q;
  logic [31:0]         rd_q;

  logic       full, empty, store_hit, push, pop, baud_last, busy;
  logic [7:0] head;
  logic [3:0] cnt4;
  logic [31:0] status;
  logic       unused_ok;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign store_hit = sel & WE & (A == 2'd0) & byteena[0];
  assign push      = store_hit & ~full;
  assign memWait   = store_hit & full;
  assign baud_last = (baud_q == BAUD_LAST);
  assign busy      = (state_q != S_IDLE);
  assign head      = mem_q[rd_ptr_q];
  // The head is consumed from IDLE, or at the end of a stop bit for back-to-back frames.
  assign pop       = ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_last));
  assign cnt4      = 4'(count_q);
  assign status    = {24'b0, cnt4, 1'b0, busy, empty, full};
  assign unused_ok = ^{WD[31:8], byteena[3:1]};

  // FIFO storage (no reset needed: validity tracked by count/pointers)
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= WD[7:0];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmitter FSM with registered serial output
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= head;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q   <= '0;
            bitcnt_q <= '0;
            state_q  <= S_DATA;
            tx_q     <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q   <= '0;
            shift_q  <= {1'b0, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= head;
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          baud_q  <= '0;
        end
      endcase
    end
  end

  // Load port: STATUS at offset 1, everything else reads zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q <= '0;
    end else if (sel & RE) begin
      rd_q <= (A == 2'd1) ? status : 32'd0;
    end
  end

  assign RD = rd_q;
  assign TX = tx_q;

endmodule
